// File: rtl/bip_pkg.sv
// Shared encodings and default widths for the BIP-I accumulator datapath.
package bip_pkg;

  localparam int DEF_NB_DATA    = 16;
  localparam int DEF_NB_OPERAND = 11;
  localparam int DEF_NB_ADDR    = 11;
  localparam int DEF_NB_OPCODE  = 5;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;
  localparam logic [1:0] SELA_ACC = 2'b11;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bip_alu.sv
// Combinational add/subtract unit; result wraps modulo 2^NB_DATA.
module bip_alu
  import bip_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic               i_op,
  output logic [NB_DATA-1:0] o_result
);

  always_comb begin
    o_result = i_a + i_b;
    if (i_op == OP_SUB) o_result = i_a - i_b;
  end

endmodule

// File: rtl/bip_datapath.sv
// BIP-I datapath: accumulator, operand sign extension, source muxes and ALU.
// Define BIP_DATAPATH_FLAGS_EN to add the o_zero / o_neg status outputs.
module bip_datapath
  import bip_pkg::*;
#(
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int NB_OPERAND = DEF_NB_OPERAND,
  parameter int NB_ADDR    = DEF_NB_ADDR,
  parameter int NB_OPCODE  = DEF_NB_OPCODE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_SelA,
  input  logic                  i_SelB,
  input  logic                  i_WrAcc,
  input  logic                  i_op,
  input  logic [NB_OPERAND-1:0] i_operand,
  input  logic [NB_DATA-1:0]    i_data_memory,
  output logic [NB_ADDR-1:0]    o_addr,
`ifdef BIP_DATAPATH_FLAGS_EN
  output logic                  o_zero,
  output logic                  o_neg,
`endif
  output logic [NB_DATA-1:0]    o_data_memory
);

  logic [NB_DATA-1:0] r_acc;
  logic [NB_DATA-1:0] w_ext;
  logic [NB_DATA-1:0] w_mux_b;
  logic [NB_DATA-1:0] w_alu;
  logic [NB_DATA-1:0] w_mux_a;

  // NB_OPCODE only exists so the parameter list matches the control unit.
  if (NB_DATA <= NB_OPERAND || NB_OPCODE < 1) begin : g_bad_params
    $error("bip_datapath: NB_DATA must exceed NB_OPERAND and NB_OPCODE must be positive");
  end

  assign w_ext   = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
  assign w_mux_b = i_SelB ? w_ext : i_data_memory;

  bip_alu #(
    .NB_DATA (NB_DATA)
  ) u_alu (
    .i_a      (r_acc),
    .i_b      (w_mux_b),
    .i_op     (i_op),
    .o_result (w_alu)
  );

  always_comb begin
    w_mux_a = r_acc;
    case (i_SelA)
      SELA_MEM: w_mux_a = i_data_memory;
      SELA_IMM: w_mux_a = w_ext;
      SELA_ALU: w_mux_a = w_alu;
      default:  w_mux_a = r_acc;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_WrAcc) begin
      r_acc <= w_mux_a;
    end
  end

  if (NB_ADDR <= NB_OPERAND) begin : g_addr_trunc
    assign o_addr = i_operand[NB_ADDR-1:0];
  end else begin : g_addr_zext
    assign o_addr = {{(NB_ADDR-NB_OPERAND){1'b0}}, i_operand};
  end

  assign o_data_memory = r_acc;

`ifdef BIP_DATAPATH_FLAGS_EN
  assign o_zero = (r_acc == '0);
  assign o_neg  = r_acc[NB_DATA-1];
`endif

endmodule

// File: tb/tb_bip_datapath.sv
// Scoreboard bench for bip_datapath: expected ACC values are queued at drive time
// and popped after the active edge.
module tb_bip_datapath;
  import bip_pkg::*;

  logic        i_clk;
  logic        i_rst;
  logic [1:0]  i_SelA;
  logic        i_SelB;
  logic        i_WrAcc;
  logic        i_op;
  logic [10:0] i_operand;
  logic [15:0] i_data_memory;
  logic [10:0] o_addr;
  logic [15:0] o_data_memory;
`ifdef BIP_DATAPATH_FLAGS_EN
  logic        o_zero;
  logic        o_neg;
`endif

  int n_vec;
  int n_err;
  logic [15:0] sb_q[$];
  logic [15:0] m_acc;

  bip_datapath #(
    .NB_DATA    (16),
    .NB_OPERAND (11),
    .NB_ADDR    (11),
    .NB_OPCODE  (5)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_SelA        (i_SelA),
    .i_SelB        (i_SelB),
    .i_WrAcc       (i_WrAcc),
    .i_op          (i_op),
    .i_operand     (i_operand),
    .i_data_memory (i_data_memory),
    .o_addr        (o_addr),
`ifdef BIP_DATAPATH_FLAGS_EN
    .o_zero        (o_zero),
    .o_neg         (o_neg),
`endif
    .o_data_memory (o_data_memory)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input logic [15:0] exp);
    chk(tag, o_data_memory, exp);
`ifdef BIP_DATAPATH_FLAGS_EN
    chk({tag, "_zero"}, {15'd0, o_zero}, {15'd0, exp == 16'd0});
    chk({tag, "_neg"}, {15'd0, o_neg}, {15'd0, exp[15]});
`endif
  endtask

  // Drive one instruction at the falling edge, check after the next rising edge.
  task automatic step(input string tag, input logic [1:0] sela, input logic selb,
                      input logic wr, input logic op, input logic [10:0] opd,
                      input logic [15:0] mem, input logic [15:0] exp);
    logic [15:0] e;
    @(negedge i_clk);
    i_SelA = sela; i_SelB = selb; i_WrAcc = wr; i_op = op;
    i_operand = opd; i_data_memory = mem;
    sb_q.push_back(exp);
    #1 chk({tag, "_addr"}, {5'd0, o_addr}, {5'd0, opd});
    @(posedge i_clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      chk_acc(tag, e);
    end
    m_acc = exp;
  endtask

  function automatic logic [15:0] sext(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  initial begin
    logic [1:0]  r_sela;
    logic        r_selb, r_wr, r_op;
    logic [10:0] r_opd;
    logic [15:0] r_mem, b, alu, nxt;
    n_vec = 0; n_err = 0; m_acc = 16'd0;
    i_rst = 1'b1; i_SelA = SELA_ACC; i_SelB = 1'b0; i_WrAcc = 1'b0;
    i_op = OP_ADD; i_operand = 11'd0; i_data_memory = 16'd0;
    #12 chk_acc("reset", 16'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    step("ldi_1",    SELA_IMM, 1'b0, 1'b1, OP_ADD, 11'd1,     16'h0000, 16'h0001);
    step("add_mem",  SELA_ALU, 1'b0, 1'b1, OP_ADD, 11'd20,    16'h0004, 16'h0005);
    step("addi_5",   SELA_ALU, 1'b1, 1'b1, OP_ADD, 11'd5,     16'h0000, 16'h000A);
    step("sub_mem",  SELA_ALU, 1'b0, 1'b1, OP_SUB, 11'd21,    16'h0008, 16'h0002);
    step("subi_3",   SELA_ALU, 1'b1, 1'b1, OP_SUB, 11'd3,     16'h0000, 16'hFFFF);
    step("ldi_7ff",  SELA_IMM, 1'b0, 1'b1, OP_ADD, 11'h7FF,   16'h0000, 16'hFFFF);
    step("ldi_3ff",  SELA_IMM, 1'b0, 1'b1, OP_ADD, 11'h3FF,   16'h0000, 16'h03FF);
    for (int k = 0; k < 5; k++)
      step("hold", 2'(k), k[0], 1'b0, ~k[0], 11'(k * 37), 16'h5A5A, 16'h03FF);
    step("ld_mem",   SELA_MEM, 1'b0, 1'b1, OP_ADD, 11'd9,     16'h1234, 16'h1234);
    step("addi_neg", SELA_ALU, 1'b1, 1'b1, OP_ADD, 11'h7FE,   16'h0000, 16'h1232);
    step("add_wrap", SELA_ALU, 1'b0, 1'b1, OP_ADD, 11'd2,     16'hEDCE, 16'h0000);

    // Mid-run asynchronous clear with a load pending.
    step("ld_pre",   SELA_MEM, 1'b0, 1'b1, OP_ADD, 11'd4,     16'hBEEF, 16'hBEEF);
    @(negedge i_clk);
    i_SelA = SELA_IMM; i_WrAcc = 1'b1; i_operand = 11'd5;
    #2 i_rst = 1'b1;
    #1 chk_acc("rst_async", 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk);
      #1 chk_acc("rst_held", 16'd0);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    i_operand = 11'd7;
    sb_q.push_back(16'h0007);
    @(posedge i_clk);
    #1 chk_acc("rst_first_load", sb_q.pop_front());
    m_acc = 16'h0007;

    // Random instructions against a reference model.
    for (int k = 0; k < 40; k++) begin
      r_sela = 2'($urandom_range(0, 3));
      r_selb = 1'($urandom_range(0, 1));
      r_wr   = ($urandom_range(0, 3) != 0);
      r_op   = 1'($urandom_range(0, 1));
      r_opd  = 11'($urandom);
      r_mem  = 16'($urandom);
      b   = r_selb ? sext(r_opd) : r_mem;
      alu = r_op ? (m_acc - b) : (m_acc + b);
      case (r_sela)
        2'b00:   nxt = r_mem;
        2'b01:   nxt = sext(r_opd);
        2'b10:   nxt = alu;
        default: nxt = m_acc;
      endcase
      if (!r_wr) nxt = m_acc;
      step("rand", r_sela, r_selb, r_wr, r_op, r_opd, r_mem, nxt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
